// File: rtl/hdmi_tpg_pkg.sv
// Shared types and constants for the hdmi_tpg test-pattern source.
package hdmi_tpg_pkg;

  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // 8-entry colour-bar table, bar 0 at the left edge
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    logic [PIX_W-1:0] c;
    c = '0;
    case (idx)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_tpg_if.sv
// Video output bundle: sync, data enable and pixel data.
interface hdmi_tpg_if;
  logic        hdmi_vs;
  logic        hdmi_hs;
  logic        hdmi_de;
  logic [31:0] hdmi_data;

  modport master (output hdmi_vs, output hdmi_hs, output hdmi_de, output hdmi_data);
  modport slave  (input  hdmi_vs, input  hdmi_hs, input  hdmi_de, input  hdmi_data);
endinterface

// File: rtl/hdmi_timing_cnt.sv
// Raster h/v counters with combinational sync, data-enable, x/y and frame strobes.
module hdmi_timing_cnt #(
  parameter  int unsigned HORIZONTAL_RES = 64,
  parameter  int unsigned VERTICAL_RES   = 64,
  parameter  int unsigned H_FRONT        = 4,
  parameter  int unsigned H_SYNC         = 8,
  parameter  int unsigned H_BACK         = 4,
  parameter  int unsigned V_FRONT        = 2,
  parameter  int unsigned V_SYNC         = 2,
  parameter  int unsigned V_BACK         = 2,
  localparam int unsigned H_TOTAL        = HORIZONTAL_RES + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL        = V_SYNC + V_BACK + VERTICAL_RES + V_FRONT,
  localparam int unsigned XW             = $clog2(H_TOTAL),
  localparam int unsigned YW             = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hs_n,
  output logic          vs_n,
  output logic          de,
  output logic          frame_start,
  output logic          frame_end
);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          line_end;
  logic          last_line;

  assign line_end  = (h_cnt == XW'(H_TOTAL - 1));
  assign last_line = (v_cnt == YW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= last_line ? '0 : v_cnt + YW'(1);
    end else begin
      h_cnt <= h_cnt + XW'(1);
    end
  end

  // line order: active, front, sync, back; frame order: sync, back, active, front
  assign hs_n = !((h_cnt >= XW'(HORIZONTAL_RES + H_FRONT)) &&
                  (h_cnt <  XW'(HORIZONTAL_RES + H_FRONT + H_SYNC)));
  assign vs_n = !(v_cnt < YW'(V_SYNC));
  assign de   = (h_cnt < XW'(HORIZONTAL_RES)) &&
                (v_cnt >= YW'(V_SYNC + V_BACK)) &&
                (v_cnt <  YW'(V_SYNC + V_BACK + VERTICAL_RES));

  assign x = h_cnt;
  assign y = v_cnt - YW'(V_SYNC + V_BACK);

  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = run && line_end && last_line;

endmodule

// File: rtl/hdmi_tpg.sv
// Video timing + test-pattern source. Define TPG_BORDER_EN to force a white
// one-pixel border around the active area in every mode.
module hdmi_tpg
  import hdmi_tpg_pkg::*;
#(
  parameter int unsigned HORIZONTAL_RES = 64,
  parameter int unsigned VERTICAL_RES   = 64,
  parameter int unsigned H_FRONT        = 4,
  parameter int unsigned H_SYNC         = 8,
  parameter int unsigned H_BACK         = 4,
  parameter int unsigned V_FRONT        = 2,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 2
) (
  input  logic              hdmi_clk,
  input  logic              hdmi_rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  solid_rgb,
  hdmi_tpg_if.master        vid,
  output logic [7:0]        frame_cnt,
  output logic              busy
);

  localparam int unsigned H_TOTAL = HORIZONTAL_RES + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + VERTICAL_RES + V_FRONT;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = XW + 4;

  state_e           state_q, state_d;
  logic             run;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             hs_n, vs_n, de, frame_start, frame_end;
  mode_e            mode_q;
  logic [PIX_W-1:0] rgb_q;
  logic [7:0]       fc_q;
  logic [7:0]       x8, y8;
  logic [PW-1:0]    bar_prod;
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] pix;

  assign run  = (state_q != ST_IDLE);
  assign busy = run;

  hdmi_timing_cnt #(
    .HORIZONTAL_RES (HORIZONTAL_RES),
    .VERTICAL_RES   (VERTICAL_RES),
    .H_FRONT        (H_FRONT),
    .H_SYNC         (H_SYNC),
    .H_BACK         (H_BACK),
    .V_FRONT        (V_FRONT),
    .V_SYNC         (V_SYNC),
    .V_BACK         (V_BACK)
  ) u_timing (
    .clk         (hdmi_clk),
    .rst_n       (hdmi_rst_n),
    .run         (run),
    .x           (x),
    .y           (y),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .de          (de),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // STOP keeps the raster running untouched; only the frame-end decision differs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (frame_end)    state_d = enable ? ST_RUN : ST_IDLE;
        else if (!enable) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (frame_end)   state_d = ST_IDLE;
        else if (enable) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      frame_cnt <= '0;
      mode_q    <= MODE_BARS;
      rgb_q     <= '0;
      fc_q      <= '0;
    end else begin
      if (frame_start) begin
        mode_q <= mode_e'(mode);
        rgb_q  <= solid_rgb;
        fc_q   <= frame_cnt;
      end
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign x8 = 8'(x);
  assign y8 = 8'(y);

  always_comb begin
    bar_prod = PW'(x) << 3;
    bar_idx  = 3'(bar_prod / PW'(HORIZONTAL_RES));
    pix      = '0;
    case (mode_q)
      MODE_BARS:  pix = bar_color(bar_idx);
      MODE_GRAD:  pix = {x8, y8, fc_q};
      MODE_SOLID: pix = rgb_q;
      MODE_CHECK: pix = (x8[3] ^ y8[3]) ? '0 : '1;
      default:    pix = '0;
    endcase
`ifdef TPG_BORDER_EN
    if ((x == '0) || (x == XW'(HORIZONTAL_RES - 1)) ||
        (y == '0) || (y == YW'(VERTICAL_RES - 1)))
      pix = '1;
`endif
  end

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      vid.hdmi_vs   <= 1'b1;
      vid.hdmi_hs   <= 1'b1;
      vid.hdmi_de   <= 1'b0;
      vid.hdmi_data <= '0;
    end else if (!run) begin
      vid.hdmi_vs   <= 1'b1;
      vid.hdmi_hs   <= 1'b1;
      vid.hdmi_de   <= 1'b0;
      vid.hdmi_data <= '0;
    end else begin
      vid.hdmi_vs   <= vs_n;
      vid.hdmi_hs   <= hs_n;
      vid.hdmi_de   <= de;
      vid.hdmi_data <= de ? {8'h00, pix} : '0;
    end
  end

endmodule

// File: tb/tb_hdmi_tpg.sv
// Randomized self-checking bench for hdmi_tpg against a frame-position reference model.
module tb_hdmi_tpg;

  localparam int HR = 64, VR = 64;
  localparam int HF = 4, HS = 8, HB = 4;
  localparam int VF = 2, VS = 2, VB = 2;
  localparam int HT = HR + HF + HS + HB;
  localparam int VT = VS + VB + VR + VF;
  localparam int ST = 11;  // small instance: 11 x 11 raster

  logic        clk = 1'b0;
  logic        rst_n, rst_s_n;
  logic        enable, en_s;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  frame_cnt, fc_s;
  logic        busy, busy_s;

  hdmi_tpg_if vid();
  hdmi_tpg_if vid_s();

  always #5 clk = ~clk;

  hdmi_tpg u_dut (
    .hdmi_clk   (clk),
    .hdmi_rst_n (rst_n),
    .enable     (enable),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .vid        (vid),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  hdmi_tpg #(
    .HORIZONTAL_RES (8),
    .VERTICAL_RES   (8),
    .H_FRONT        (1),
    .H_SYNC         (1),
    .H_BACK         (1),
    .V_FRONT        (1),
    .V_SYNC         (1),
    .V_BACK         (1)
  ) u_small (
    .hdmi_clk   (clk),
    .hdmi_rst_n (rst_s_n),
    .enable     (en_s),
    .mode       (2'd0),
    .solid_rgb  (24'h0),
    .vid        (vid_s),
    .frame_cnt  (fc_s),
    .busy       (busy_s)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: position within the frame, run/stop flags, latched frame settings
  bit          m_run, m_stop;
  int          m_pos, m_frames, m_lmode, m_lfc;
  logic [23:0] m_lrgb;
  logic [34:0] exp_vid;
  int          edge_no, entry_edge, first_de_edge;
  int          de_cnt, vs_cnt, solid_cnt;
  int          fc_edge_prev, fc_edge_last;
  logic [7:0]  prev_fc_obs;
  bit          small_done;

  function automatic logic [23:0] ref_pixel(input int md, input logic [23:0] rgb,
                                            input int fc, input int x, input int y);
    logic [23:0] bars [8];
    logic [23:0] p;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (md)
      0:       p = bars[(x * 8) / HR];
      1:       p = {8'(x), 8'(y), 8'(fc)};
      2:       p = rgb;
      default: p = (((x / 8) + (y / 8)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
    endcase
`ifdef TPG_BORDER_EN
    if (x == 0 || x == HR - 1 || y == 0 || y == VR - 1) p = 24'hFFFFFF;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_pos = 0; m_frames = 0;
    m_lmode = 0; m_lrgb = '0; m_lfc = 0;
    exp_vid = {1'b1, 1'b1, 1'b0, 32'h0};
  endtask

  task automatic model_edge();
    int h, v;
    bit vs_e, hs_e, de_e;
    if (!m_run) begin
      exp_vid = {1'b1, 1'b1, 1'b0, 32'h0};
      if (enable) begin
        m_run = 1; m_pos = 0; m_stop = 0;
        entry_edge = edge_no + 1;
      end
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      if (m_pos == 0) begin
        m_lmode = int'(mode); m_lrgb = solid_rgb; m_lfc = m_frames;
      end
      vs_e = (v >= VS);
      hs_e = !(h >= HR + HF && h < HR + HF + HS);
      de_e = (h < HR) && (v >= VS + VB) && (v < VS + VB + VR);
      exp_vid = {vs_e, hs_e, de_e,
                 de_e ? {8'h00, ref_pixel(m_lmode, m_lrgb, m_lfc, h, v - VS - VB)} : 32'h0};
      if (m_pos == HT * VT - 1) begin
        m_frames = (m_frames + 1) % 256;
        if (enable && !m_stop) m_pos = 0;
        else                   m_run = 0;
      end else begin
        m_pos++;
        m_stop = !enable;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    check("raster", {vid.hdmi_vs, vid.hdmi_hs, vid.hdmi_de, vid.hdmi_data}, exp_vid);
    check("frame_cnt", frame_cnt, 64'(m_frames));
    check("busy", busy, 64'(m_run));
    if (vid.hdmi_de) de_cnt++;
    if (!vid.hdmi_vs) vs_cnt++;
    if (vid.hdmi_de && first_de_edge < 0) first_de_edge = edge_no;
    if (vid.hdmi_de && vid.hdmi_data == 32'h00123456) solid_cnt++;
    if (frame_cnt != prev_fc_obs) begin
      fc_edge_prev = fc_edge_last;
      fc_edge_last = edge_no;
      prev_fc_obs  = frame_cnt;
    end
  endtask

  task automatic run_to(input int target, input bit rnd);
    int guard = 0;
    while (m_pos != target && guard < 2 * HT * VT) begin
      if (rnd && $urandom_range(0, 399) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        solid_rgb = 24'($urandom);
      end
      step();
      guard++;
    end
    if (guard >= 2 * HT * VT) check("run_to_bound", 64'(guard), 64'(0));
  endtask

  task automatic check_idle_now(input string tag);
    check({tag, "_vs"},   vid.hdmi_vs,   1);
    check({tag, "_hs"},   vid.hdmi_hs,   1);
    check({tag, "_de"},   vid.hdmi_de,   0);
    check({tag, "_data"}, vid.hdmi_data, 0);
    check({tag, "_fc"},   frame_cnt,     0);
    check({tag, "_busy"}, busy,          0);
  endtask

  initial begin
    int g;
    enable = 0; mode = 2'd0; solid_rgb = '0;
    rst_n = 1; rst_s_n = 1;
    edge_no = 0; entry_edge = 0; first_de_edge = -1;
    de_cnt = 0; vs_cnt = 0; solid_cnt = 0;
    fc_edge_prev = 0; fc_edge_last = 0; prev_fc_obs = '0;
    model_reset();
    #1 rst_n = 0; rst_s_n = 0;
    #1 check_idle_now("reset");
    repeat (3) @(negedge clk);
    rst_n = 1; rst_s_n = 1;
    repeat (5) step();

    // frame 1: colour bars, raster timing
    mode = 2'd0; enable = 1;
    step();
    first_de_edge = -1; de_cnt = 0; vs_cnt = 0;
    repeat (HT * VT) step();
    check("de_per_frame", 64'(de_cnt), 64'(HR * VR));
    check("vs_low_cycles", 64'(vs_cnt), 64'(VS * HT));
    check("first_de_edge", 64'(first_de_edge - entry_edge), 64'((VS + VB) * HT + 1));

    // frame 2: switch to solid at line 30, must stay bars until frame 3
    run_to(30 * HT, 0);
    mode = 2'd2; solid_rgb = 24'h123456;
    run_to(0, 0);
    check("frame_period", 64'(fc_edge_last - fc_edge_prev), 64'(HT * VT));
    solid_cnt = 0;
    run_to(HT, 0);
    mode = 2'd1;
    run_to(0, 0);
    check("solid_pixels", 64'(solid_cnt), 64'(HR * VR));

    // frame 4: gradient with random mid-frame input churn and a short stop/resume
    step();
    run_to(20 * HT + $urandom_range(0, 20 * HT), 1);
    enable = 0;
    repeat ($urandom_range(1, 40)) step();
    enable = 1;
    run_to(HT * VT - 1, 1);
    mode = 2'd3; solid_rgb = 24'($urandom);

    // frame 5: checkerboard, enable dropped at line 10
    run_to(0, 0);
    de_cnt = 0;
    run_to(10 * HT, 0);
    enable = 0;
    g = 0;
    while (m_run && g < 2 * HT * VT) begin
      step();
      g++;
    end
    check("stop_de_pixels", 64'(de_cnt), 64'(HR * VR));
    repeat (40) step();
    enable = 1;
    step();
    step();
    check("restart_vs_low", vid.hdmi_vs, 0);
    repeat (1500) step();

    // asynchronous reset mid-frame
    #2 rst_n = 0;
    #1 check_idle_now("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (400) step();

    g = 0;
    while (!small_done && g < 40000) begin
      @(negedge clk);
      g++;
    end
    if (!small_done) check("small_done", 64'(small_done), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // frame counter wrap on the small raster: 257 frames of ST*ST cycles
  initial begin
    small_done = 0;
    en_s = 0;
    @(posedge rst_s_n);
    @(negedge clk);
    en_s = 1;
    @(posedge clk);
    repeat (ST * ST * 255) @(posedge clk);
    @(negedge clk);
    check("wrap_255", fc_s, 255);
    repeat (ST * ST) @(posedge clk);
    @(negedge clk);
    check("wrap_0", fc_s, 0);
    repeat (ST * ST) @(posedge clk);
    @(negedge clk);
    check("wrap_1", fc_s, 1);
    check("small_busy", busy_s, 1);
    en_s = 0;
    small_done = 1;
  end

endmodule
